freq_meter: RTL and testbench

//  Gated frequency counter that produces the 16-bit binary value `dec` for the seven-segment output stage.

---
 rtl/freq_meter_pkg.sv | 18 +
 rtl/freq_meter_if.sv | 16 +
 rtl/sync_edge_det.sv | 26 ++
 rtl/freq_meter.sv | 137 +++++++++++++
 tb/tb_freq_meter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GATE  = 2'd1,
        S_LATCH = 2'd2
    } state_e;

    localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
    localparam int unsigned TMR_W           = $clog2(GATE_CYCLES_DEF);

    // Timer width for a given gate length; the timer holds at most cycles-1.
    function automatic int unsigned tmr_width(input int unsigned cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control and result bundle between the frequency meter and its neighbours.
interface freq_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic             sig_in;
    logic [CNT_W-1:0] dec;
    logic             dec_valid;
    logic             ovf;
    logic             gating;

    modport master (output run, output sig_in,
                    input  dec, input dec_valid, input ovf, input gating);
    modport slave  (input  run, input  sig_in,
                    output dec, output dec_valid, output ovf, output gating);
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by rising-edge detection.
module sync_edge_det (
    input  logic clk,
    input  logic clr_n,
    input  logic d_async,
    output logic rise_pulse
);
    logic meta_q;
    logic sync_q;
    logic edge_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= d_async;
            sync_q <= meta_q;
            edge_q <= sync_q;
        end
    end

    assign rise_pulse = sync_q & ~edge_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges per gate and publishes dec once per gate.
// Define FREQ_METER_AVG2_EN to publish the mean of the current and previous gate counts.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_COUNT   = 9999
) (
    input  logic         clk,
    input  logic         clr_n,
    freq_meter_if.slave  bus
);
    localparam int unsigned    TMR_BITS = tmr_width(GATE_CYCLES);
    localparam logic [TMR_BITS-1:0] TMR_LOAD = TMR_BITS'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_COUNT);

    state_e              state_q, state_d;
    logic [TMR_BITS-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    dec_q, dec_d;
    logic [CNT_W-1:0]    pub_c;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic                gating_q;
    logic                sig_edge;

    sync_edge_det u_sync (
        .clk        (clk),
        .clr_n      (clr_n),
        .d_async    (bus.sig_in),
        .rise_pulse (sig_edge)
    );

`ifdef FREQ_METER_AVG2_EN
    // Previous gate's count: kept on publish, cleared on abort.
    logic [CNT_W-1:0] prev_q;
    logic [CNT_W:0]   sum_c;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prev_q <= '0;
        end else if (state_q == S_LATCH) begin
            prev_q <= count_q;
        end else if (state_q == S_GATE && !bus.run) begin
            prev_q <= '0;
        end
    end

    assign sum_c = {1'b0, count_q} + {1'b0, prev_q};
    assign pub_c = sum_c[CNT_W:1];
`else
    assign pub_c = count_q;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            dec_q    <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            gating_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            dec_q    <= dec_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            gating_q <= (state_d == S_GATE);
        end
    end

    // Next state, gate timer, saturating counter and publish values.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        dec_d   = dec_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                count_d = '0;
                if (bus.run) begin
                    state_d = S_GATE;
                    timer_d = TMR_LOAD;
                end
            end
            S_GATE: begin
                if (!bus.run) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    count_d = '0;
                end else begin
                    if (sig_edge && count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (timer_q == '0) begin
                        state_d = S_LATCH;
                    end else begin
                        timer_d = timer_q - TMR_BITS'(1);
                    end
                end
            end
            S_LATCH: begin
                dec_d   = pub_c;
                ovf_d   = (count_q == CNT_MAX);
                valid_d = 1'b1;
                // An edge seen here opens the next gate's count.
                count_d = sig_edge ? CNT_W'(1) : '0;
                timer_d = TMR_LOAD;
                if (bus.run) begin
                    state_d = S_GATE;
                end else begin
                    state_d = S_IDLE;
                    count_d = '0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                count_d = '0;
            end
        endcase
    end

    assign bus.dec       = dec_q;
    assign bus.dec_valid = valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.gating    = gating_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (ceilings 9999 and 7) share stimulus and a window-sum model.
module tb_freq_meter;

    localparam int unsigned G     = 100;
    localparam int unsigned CW    = 16;
    localparam int          MAX_A = 9999;
    localparam int          MAX_B = 7;
    localparam int          MAXC  = 16384;
`ifdef FREQ_METER_AVG2_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    logic run_r = 1'b0;
    logic gen_sig = 1'b0;
    logic man_sig = 1'b0;
    bit   gen_en  = 1'b1;
    int   per     = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(CW)) bus_a ();
    freq_meter_if #(.CNT_W(CW)) bus_b ();

    assign bus_a.run    = run_r;
    assign bus_b.run    = run_r;
    assign bus_a.sig_in = gen_en ? gen_sig : man_sig;
    assign bus_b.sig_in = gen_en ? gen_sig : man_sig;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CW), .MAX_COUNT(MAX_A)) dut_a (
        .clk(clk), .clr_n(clr_n), .bus(bus_a.slave));
    freq_meter #(.GATE_CYCLES(G), .CNT_W(CW), .MAX_COUNT(MAX_B)) dut_b (
        .clk(clk), .clr_n(clr_n), .bus(bus_b.slave));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Periodic square wave (per>=2), random bits (per==1), or low (per<=0).
    initial begin : gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (per <= 0) begin
                gen_sig = 1'b0;
                ph = 0;
            end else if (per == 1) begin
                gen_sig = 1'($urandom_range(0, 1));
            end else begin
                gen_sig = (ph < per / 2);
                ph = (ph + 1) % per;
            end
        end
    end

    // Model: an edge is credited two clocks after sig_in is sampled high following a low;
    // each publish reports the sum of credited edges over its measurement window.
    bit s_hist [MAXC];
    bit ev     [MAXC];
    int n = 0;
    bit active = 1'b0;
    int win_lo = 0, pub_at = 0;
    int prev_a = 0, prev_b = 0;
    int exp_dec_a = 0, exp_dec_b = 0;
    bit exp_ovf_a = 1'b0, exp_ovf_b = 1'b0, exp_valid = 1'b0, exp_gating = 1'b0;

    initial begin : model
        int raw, sat_a, sat_b;
        bit s2, s3;
        forever begin
            @(posedge clk or negedge clr_n);
            if (!clr_n) begin
                n = 0; active = 1'b0; prev_a = 0; prev_b = 0;
                exp_dec_a = 0; exp_dec_b = 0; exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
                exp_valid = 1'b0; exp_gating = 1'b0;
            end else begin
                if (n >= MAXC) begin
                    $display("FAIL model_capacity: cycle %0d, limit %0d", n, MAXC);
                    $fatal(1, "model history exhausted");
                end
                s_hist[n] = bus_a.sig_in;
                s2 = (n >= 2) ? s_hist[n-2] : 1'b0;
                s3 = (n >= 3) ? s_hist[n-3] : 1'b0;
                ev[n] = s2 & ~s3;
                exp_valid = 1'b0;
                if (!active) begin
                    if (run_r) begin
                        active = 1'b1;
                        win_lo = n + 1;
                        pub_at = n + int'(G) + 1;
                    end
                end else if (n == pub_at) begin
                    raw = 0;
                    for (int k = win_lo; k < n; k++) raw += int'(ev[k]);
                    sat_a = (raw > MAX_A) ? MAX_A : raw;
                    sat_b = (raw > MAX_B) ? MAX_B : raw;
                    exp_dec_a = AVG ? (sat_a + prev_a) / 2 : sat_a;
                    exp_dec_b = AVG ? (sat_b + prev_b) / 2 : sat_b;
                    exp_ovf_a = (sat_a == MAX_A);
                    exp_ovf_b = (sat_b == MAX_B);
                    prev_a = sat_a;
                    prev_b = sat_b;
                    exp_valid = 1'b1;
                    if (run_r) begin
                        win_lo = n;
                        pub_at = n + int'(G) + 1;
                    end else begin
                        active = 1'b0;
                    end
                end else if (!run_r) begin
                    active = 1'b0;
                    prev_a = 0;
                    prev_b = 0;
                end
                exp_gating = active && (n < pub_at - 1);
                n++;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("dec_a",       int'(bus_a.dec),       exp_dec_a);
            chk("dec_valid_a", int'(bus_a.dec_valid), int'(exp_valid));
            chk("ovf_a",       int'(bus_a.ovf),       int'(exp_ovf_a));
            chk("gating_a",    int'(bus_a.gating),    int'(exp_gating));
            chk("dec_b",       int'(bus_b.dec),       exp_dec_b);
            chk("dec_valid_b", int'(bus_b.dec_valid), int'(exp_valid));
            chk("ovf_b",       int'(bus_b.ovf),       int'(exp_ovf_b));
            chk("gating_b",    int'(bus_b.gating),    int'(exp_gating));
        end
    end

    // Negedges until dec_valid is seen, bounded.
    task automatic wait_valid(input int bound, output int t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus_a.dec_valid && t < bound);
        if (!bus_a.dec_valid) chk("wait_valid_timeout", t, -1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dec"},    int'(bus_a.dec),       0);
        chk({tag, "_valid"},  int'(bus_a.dec_valid), 0);
        chk({tag, "_ovf"},    int'(bus_a.ovf),       0);
        chk({tag, "_gating"}, int'(bus_a.gating),    0);
        chk({tag, "_dec_b"},  int'(bus_b.dec),       0);
        chk({tag, "_ovf_b"},  int'(bus_b.ovf),       0);
    endtask

    initial begin : main
        int t, k, saved, seen, off;
        int pubs[$];
        #1 clr_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        clr_n = 1'b1;

        // Period 10: dec every 101 clocks, 10 or 11 edges per gate.
        per = 10; run_r = 1'b1;
        wait_valid(300, t);
        chk("t1_first_dec", int'(bus_a.dec), AVG ? 5 : 10);
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, t);
            chk("t1_interval", t, 101);
            chk_rng("t1_dec", int'(bus_a.dec), 10, 11);
            chk("t1_ovf", int'(bus_a.ovf), 0);
        end

        // Saturation on the MAX_COUNT=7 instance, then recovery.
        per = 4;
        repeat (3) wait_valid(300, t);
        chk("t2_dec_b_sat", int'(bus_b.dec), 7);
        chk("t2_ovf_b_sat", int'(bus_b.ovf), 1);
        chk_rng("t2_dec_a", int'(bus_a.dec), 25, 26);
        chk("t2_ovf_a", int'(bus_a.ovf), 0);
        per = 20;
        repeat (3) wait_valid(300, t);
        chk_rng("t2_dec_b_low", int'(bus_b.dec), 5, 6);
        chk("t2_ovf_b_clear", int'(bus_b.ovf), 0);

        // Abort mid-gate, then a fresh full gate.
        per = 10;
        wait_valid(300, t);
        saved = int'(bus_a.dec);
        repeat (50) @(negedge clk);
        run_r = 1'b0;
        @(negedge clk);
        chk("t4_gating_off", int'(bus_a.gating), 0);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus_a.dec_valid) seen++;
        end
        chk("t4_no_valid", seen, 0);
        chk("t4_dec_hold", int'(bus_a.dec), saved);
        run_r = 1'b1;
        wait_valid(400, t);
        chk("t4_fresh_latency", t, 102);
        chk("t4_fresh_dec", int'(bus_a.dec), AVG ? 5 : 10);

        // Edge in the timer==0 cycle, then one in a LATCH cycle.
        run_r = 1'b0; gen_en = 1'b0; man_sig = 1'b0;
        repeat (6) @(negedge clk);
        k = n; run_r = 1'b1;
        pubs.delete();
        for (int i = 0; i < 310; i++) begin
            @(negedge clk);
            off = n - k;
            man_sig = (off == 98 || off == 200);
            if (bus_a.dec_valid) pubs.push_back(int'(bus_a.dec));
        end
        chk("t3_npub", pubs.size(), 3);
        if (pubs.size() == 3) begin
            chk("t3_pub0", pubs[0], AVG ? 0 : 1);
            chk("t3_pub1", pubs[1], AVG ? 0 : 0);
            chk("t3_pub2", pubs[2], AVG ? 0 : 1);
        end

        // Gate counts 10 then 13.
        run_r = 1'b0; man_sig = 1'b0;
        repeat (6) @(negedge clk);
        k = n; run_r = 1'b1;
        pubs.delete();
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            off = n - k;
            man_sig = (off >= 5 && off < 45 && (off - 5) % 4 == 0) ||
                      (off >= 110 && off < 162 && (off - 110) % 4 == 0);
            if (bus_a.dec_valid) pubs.push_back(int'(bus_a.dec));
        end
        chk("t6_npub", pubs.size(), 2);
        if (pubs.size() == 2) begin
            chk("t6_pub0", pubs[0], AVG ? 5 : 10);
            chk("t6_pub1", pubs[1], AVG ? 11 : 13);
        end

        // Asynchronous clear mid-gate.
        man_sig = 1'b0; gen_en = 1'b1; per = 10;
        wait_valid(300, t);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1 chk_zero("t5_clear");
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        wait_valid(400, t);
        chk("t5_resume_latency", t, 102);
        chk_rng("t5_resume_dec", int'(bus_a.dec), AVG ? 5 : 10, AVG ? 5 : 11);

        // Randomised rates, run drops and one asynchronous clear.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 9))
                0: per = 0;  1: per = 1;  2: per = 2;  3: per = 3;  4: per = 4;
                5: per = 5;  6: per = 7;  7: per = 10; 8: per = 13; default: per = 20;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                run_r = 1'b0;
                repeat ($urandom_range(1, 40)) @(negedge clk);
                run_r = 1'b1;
            end
            if (it == 15) begin
                @(posedge clk);
                #3 clr_n = 1'b0;
                repeat (2) @(negedge clk);
                clr_n = 1'b1;
            end
            repeat ($urandom_range(30, 300)) @(negedge clk);
        end

        run_r = 1'b0;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
